fp_addsub_pipe: RTL

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor for the FPU datapath, successor to the single-cycle combinational add/sub unit. It is generic in exponent and mantissa width, takes one operation per cycle through a valid/ready handshake, and produces a result a fixed 3 cycles later. It adds round-to-nearest-even, subnormal handling, special-value handling and exception flags. It feeds the FPU result mux.

---
 rtl/fp_addsub_pipe.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage floating-point adder/subtractor with
// round-to-nearest-even, subnormals, inf/NaN handling and exception flags.
// Ports: clk, rst (sync, active high); in_valid/in_ready, a, b, sub;
//   out_valid/out_ready, result, flg_invalid, flg_overflow, flg_inexact.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 flg_invalid,
  output logic                 flg_overflow,
  output logic                 flg_inexact
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M4  = MAN_W + 4;
  localparam int EW1 = EXP_W + 1;

  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ONE =
    {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W:0] EW1_ONE =
    {{EXP_W{1'b0}}, 1'b1};
  localparam logic [W-1:0] QNAN =
    {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             spc;
    logic             inv;
    logic [W-1:0]     spc_res;
    logic             sx;
    logic             sy;
    logic [EXP_W-1:0] ex;
    logic [M4-1:0]    mx;
    logic [M4-1:0]    my;
  } s1_t;

  typedef struct packed {
    logic             spc;
    logic             inv;
    logic [W-1:0]     spc_res;
    logic             sx;
    logic             sy;
    logic [EXP_W-1:0] ex;
    logic [M4:0]      sum;
  } s2_t;

  function automatic logic [31:0] lzc(
    input logic [M4-1:0] v
  );
    logic [31:0] n;
    logic        hit;
    n   = 32'(M4);
    hit = 1'b0;
    for (int i = M4 - 1; i >= 0; i--) begin
      if (!hit && v[i]) begin
        n   = 32'(M4 - 1 - i);
        hit = 1'b1;
      end
    end
    return n;
  endfunction

  // Whole-pipe stall: only a held output blocks.
  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  logic v1, v2;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  // ---------------- stage 1: unpack, specials, align
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             nan_a, nan_b, inf_a, inf_b;
  logic             a_ge;

  assign sa = a[W-1];
  assign sb = b[W-1] ^ sub;
  assign ea = a[W-2 -: EXP_W];
  assign eb = b[W-2 -: EXP_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];

  assign nan_a = (ea == EXP_MAX) && (fa != '0);
  assign nan_b = (eb == EXP_MAX) && (fb != '0);
  assign inf_a = (ea == EXP_MAX) && (fa == '0);
  assign inf_b = (eb == EXP_MAX) && (fb == '0);
  assign a_ge  = {ea, fa} >= {eb, fb};

  logic [EXP_W-1:0] ex_r, ey_r, ex_e, ey_e, d;
  logic [MAN_W-1:0] fx, fy;
  logic [M4-1:0]    y_full, y_shr, y_mask, y_al;
  logic             y_lost;

  always_comb begin
    ex_r = a_ge ? ea : eb;
    ey_r = a_ge ? eb : ea;
    fx   = a_ge ? fa : fb;
    fy   = a_ge ? fb : fa;
    ex_e = (ex_r == '0) ? EXP_ONE : ex_r;
    ey_e = (ey_r == '0) ? EXP_ONE : ey_r;
    d    = ex_e - ey_e;
    y_full = {ey_r != '0, fy, 3'b000};
    y_shr  = y_full >> d;
    y_mask = ~({M4{1'b1}} << d);
    y_lost = |(y_full & y_mask);
    // Far shifts collapse the whole operand into sticky.
    if (32'(d) >= 32'(M4 - 1)) begin
      y_al = {{(M4-1){1'b0}}, |y_full};
    end else begin
      y_al = {y_shr[M4-1:1], y_shr[0] | y_lost};
    end
  end

  always_comb begin
    s1_d    = '0;
    s1_d.sx = a_ge ? sa : sb;
    s1_d.sy = a_ge ? sb : sa;
    s1_d.ex = ex_e;
    s1_d.mx = {ex_r != '0, fx, 3'b000};
    s1_d.my = y_al;
    if (nan_a || nan_b ||
        (inf_a && inf_b && (sa != sb))) begin
      s1_d.spc     = 1'b1;
      s1_d.inv     = 1'b1;
      s1_d.spc_res = QNAN;
    end else if (inf_a) begin
      s1_d.spc     = 1'b1;
      s1_d.spc_res = {sa, EXP_MAX, {MAN_W{1'b0}}};
    end else if (inf_b) begin
      s1_d.spc     = 1'b1;
      s1_d.spc_res = {sb, EXP_MAX, {MAN_W{1'b0}}};
    end
  end

  // ---------------- stage 2: add / subtract
  always_comb begin
    s2_d         = '0;
    s2_d.spc     = s1_q.spc;
    s2_d.inv     = s1_q.inv;
    s2_d.spc_res = s1_q.spc_res;
    s2_d.sx      = s1_q.sx;
    s2_d.sy      = s1_q.sy;
    s2_d.ex      = s1_q.ex;
    // |X| >= |Y|, so the difference never goes negative.
    if (s1_q.sx ^ s1_q.sy) begin
      s2_d.sum = {1'b0, s1_q.mx} - {1'b0, s1_q.my};
    end else begin
      s2_d.sum = {1'b0, s1_q.mx} + {1'b0, s1_q.my};
    end
  end

  // ---------------- stage 3: normalise, round, pack
  logic [M4:0]      sm;
  logic [M4-1:0]    nm;
  logic [EXP_W:0]   ne, re;
  logic [31:0]      lz, lim, sh;
  logic             g, r, st, lsb, rup;
  logic [MAN_W+1:0] mr;
  logic [MAN_W:0]   mn;
  logic             zero, ovf;
  logic [W-1:0]     res_d;
  logic             inv_d, ovf_d, inx_d;

  assign sm = s2_q.sum;

  always_comb begin
    lz  = lzc(sm[M4-1:0]);
    lim = 32'(s2_q.ex) - 32'd1;
    sh  = '0;
    if (sm[M4]) begin
      nm = {sm[M4:2], sm[1] | sm[0]};
      ne = {1'b0, s2_q.ex} + EW1_ONE;
    end else begin
      // Never normalise below the minimum exponent.
      sh = (lz < lim) ? lz : lim;
      nm = sm[M4-1:0] << sh;
      ne = {1'b0, s2_q.ex} - EW1'(sh);
      if (!nm[M4-1]) begin
        ne = '0;
      end
    end
    g   = nm[2];
    r   = nm[1];
    st  = nm[0];
    lsb = nm[3];
    rup = g & (r | st | lsb);
    mr  = {1'b0, nm[M4-1:3]}
        + {{(MAN_W+1){1'b0}}, rup};
    re  = ne;
    if (mr[MAN_W+1]) begin
      mn = mr[MAN_W+1:1];
      re = ne + EW1_ONE;
    end else begin
      mn = mr[MAN_W:0];
      // Subnormal that rounded up into the normal range.
      if (ne == '0 && mr[MAN_W]) begin
        re = EW1_ONE;
      end
    end
    zero = (sm == '0);
    ovf  = re >= {1'b0, EXP_MAX};

    res_d = {s2_q.sx, re[EXP_W-1:0], mn[MAN_W-1:0]};
    inv_d = 1'b0;
    ovf_d = 1'b0;
    inx_d = g | r | st;
    if (s2_q.spc) begin
      res_d = s2_q.spc_res;
      inv_d = s2_q.inv;
      inx_d = 1'b0;
    end else if (ovf) begin
      res_d = {s2_q.sx, EXP_MAX, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (zero) begin
      // Only (-0)+(-0) keeps a negative zero.
      res_d = {s2_q.sx & s2_q.sy, {(W-1){1'b0}}};
    end
  end

  // ---------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      result       <= '0;
      flg_invalid  <= 1'b0;
      flg_overflow <= 1'b0;
      flg_inexact  <= 1'b0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) begin
        result       <= res_d;
        flg_invalid  <= inv_d;
        flg_overflow <= ovf_d;
        flg_inexact  <= inx_d;
      end
    end
  end

endmodule
